// File: rtl/arr_mul_seq_ctrl.sv
// arr_mul_seq_ctrl
//   Multi-cycle unsigned multiplier. It reuses one 4x4 array multiplier and
//   computes one nibble partial product per cycle. Each partial product is
//   shifted into place and added to a 2*OP_W-bit accumulator. Valid/ready
//   handshakes are used on both the operand and result sides.
//
//   Ports
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     in_valid   operands valid        in_ready   block can accept operands
//     in_a       multiplicand          in_b       multiplier
//     abort      synchronous flush, active-high
//     busy       state is CALC or DONE
//     out_valid  out_p holds a product out_ready  consumer accepts product
//     out_p      registered product, 2*OP_W bits
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   CALC  | one nibble partial product accumulated per edge
//   DONE  | product presented, held until out_ready

module array_multiplier_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  // Sum of the four AND-gated rows of the array. Each row is shifted by its
  // bit position in b.
  always_comb begin
    p = '0;
    for (int k = 0; k < 4; k++) begin
      p = p + ({4'b0000, a & {4{b[k]}}} << k);
    end
  end
endmodule

module arr_mul_seq_ctrl #(
  parameter int OP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              abort,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-1:0] out_p
);
  localparam int NW = OP_W / 4;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW = 2 * OP_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] NIB_LAST = CW'(NW - 1);

  logic [1:0]      state;
  logic [OP_W-1:0] a_q;
  logic [OP_W-1:0] b_q;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   i_cnt;
  logic [CW-1:0]   j_cnt;

  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [7:0]      nib_p;
  logic [CW:0]     nib_pos;
  logic [PW-1:0]   pp_shifted;
  logic [PW-1:0]   acc_next;
  logic            last_step;

  assign nib_a = a_q[{i_cnt, 2'b00} +: 4];
  assign nib_b = b_q[{j_cnt, 2'b00} +: 4];

  array_multiplier_4bit u_mul (
    .a (nib_a),
    .b (nib_b),
    .p (nib_p)
  );

  // The weight of A[i]*B[j] is 2^(4*(i+j)). The shift amount is the nibble
  // position sum with two zero bits appended.
  assign nib_pos    = {1'b0, i_cnt} + {1'b0, j_cnt};
  assign pp_shifted = PW'(nib_p) << {nib_pos, 2'b00};
  assign acc_next   = acc + pp_shifted;
  assign last_step  = (i_cnt == NIB_LAST) && (j_cnt == NIB_LAST);

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // abort has priority over in_valid: no operands are taken while it is high.
          if (!abort && in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            acc   <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (abort) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end else begin
            acc <= acc_next;
            if (last_step) begin
              out_p     <= acc_next;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else if (i_cnt == NIB_LAST) begin
              i_cnt <= '0;
              j_cnt <= j_cnt + 1'b1;
            end else begin
              i_cnt <= i_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          // out_p keeps its value after the handshake. Only out_valid drops.
          if (abort || out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_arr_mul_seq_ctrl.sv
// tb_arr_mul_seq_ctrl
//   Directed bench for arr_mul_seq_ctrl with OP_W=8. Inputs are driven 1 time
//   unit after each rising edge. Outputs are sampled at the same point.

module tb_arr_mul_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        abort;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;

  int total = 0;
  int bad   = 0;

  arr_mul_seq_ctrl #(.OP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One full transaction, with out_ready already high.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] expv, input string tag);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = 8'h5A;
    chk({tag, " busy"}, {31'b0, busy}, 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk({tag, " early_valid"}, {31'b0, out_valid}, 0);
    end
    tick();
    chk({tag, " valid"}, {31'b0, out_valid}, 1);
    chk({tag, " prod"}, {16'b0, out_p}, {16'b0, expv});
    tick();
    chk({tag, " back_idle"}, {31'b0, in_ready}, 1);
    chk({tag, " valid_drop"}, {31'b0, out_valid}, 0);
  endtask

  logic [7:0]  bb_a [3];
  logic [7:0]  bb_b [3];
  logic [15:0] bb_p [3];
  logic [15:0] held;
  logic        prev_busy;
  int          n;
  int          last_t;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    abort     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst in_ready", {31'b0, in_ready}, 1);
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst out_valid", {31'b0, out_valid}, 0);
    chk("rst out_p", {16'b0, out_p}, 0);
    rst_n = 1'b1;
    tick();

    run_op(8'd200, 8'd150, 16'd30000, "basic");
    run_op(8'd255, 8'd255, 16'hFE01, "max");
    run_op(8'd0,   8'd173, 16'd0,    "zero");
    run_op(8'd1,   8'd255, 16'd255,  "one");
    run_op(8'd16,  8'd16,  16'd256,  "shift");

    // Backpressure: 37*91 = 3367
    out_ready = 1'b0;
    in_a = 8'd37; in_b = 8'd91; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("bp valid", {31'b0, out_valid}, 1);
    chk("bp prod", {16'b0, out_p}, 32'd3367);
    held = out_p;
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_a = 8'd3; in_b = 8'd4;
      tick();
      chk("bp hold_p", {16'b0, out_p}, {16'b0, held});
      chk("bp hold_valid", {31'b0, out_valid}, 1);
      chk("bp in_ready", {31'b0, in_ready}, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp release_valid", {31'b0, out_valid}, 0);
    chk("bp release_idle", {31'b0, in_ready}, 1);
    chk("bp keep_p", {16'b0, out_p}, 32'd3367);
    tick();
    chk("bp no_accept", {31'b0, busy}, 0);

    // Abort on the 2nd CALC edge of 11*5
    in_a = 8'd11; in_b = 8'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", {31'b0, busy}, 0);
    chk("abort valid", {31'b0, out_valid}, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort no_valid", {31'b0, out_valid}, 0);
    end
    // abort in IDLE has priority over in_valid
    abort = 1'b1; in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7;
    tick();
    chk("abort idle_block", {31'b0, busy}, 0);
    abort = 1'b0; in_valid = 1'b0;
    run_op(8'd9, 8'd3, 16'd27, "post_abort");

    // Back-to-back with in_valid held high
    bb_a = '{8'd12, 8'd250, 8'd99};
    bb_b = '{8'd13, 8'd3,   8'd201};
    bb_p = '{16'd156, 16'd750, 16'd19899};
    n = 0;
    last_t = 0;
    in_a = bb_a[0]; in_b = bb_b[0]; in_valid = 1'b1;
    prev_busy = busy;
    for (int c = 1; c <= 40 && n < 3; c++) begin
      tick();
      if (busy && !prev_busy) begin
        in_a = 8'hFF;
        in_b = 8'hEE;
      end
      if (out_valid) begin
        chk("b2b prod", {16'b0, out_p}, {16'b0, bb_p[n]});
        if (n > 0) chk("b2b spacing", c - last_t, 6);
        last_t = c;
        n++;
        if (n < 3) begin
          in_a = bb_a[n];
          in_b = bb_b[n];
        end else begin
          in_valid = 1'b0;
        end
      end
      prev_busy = busy;
    end
    in_valid = 1'b0;
    chk("b2b count", n, 3);
    tick();
    tick();

    // Asynchronous reset in the middle of CALC
    in_a = 8'd200; in_b = 8'd150; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid busy", {31'b0, busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("async out_valid", {31'b0, out_valid}, 0);
    chk("async in_ready", {31'b0, in_ready}, 1);
    chk("async out_p", {16'b0, out_p}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
